// File: rtl/pi1_streamldr.sv
// PI1 bus initiator that packs an incoming byte stream little-endian into
// ARCHBITSZ-bit words and writes them to consecutive word addresses.
module pi1_streamldr #(
  parameter int ARCHBITSZ = 32,
  parameter int ADDRBITSZ = ARCHBITSZ - $clog2(ARCHBITSZ/8)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [ADDRBITSZ-1:0]   base_addr_i,
  input  logic [ADDRBITSZ-1:0]   wcnt_i,
  input  logic [7:0]             in_data_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [ARCHBITSZ-1:0]   sum_o,
  output logic [1:0]             pi1_op_o,
  output logic [ADDRBITSZ-1:0]   pi1_addr_o,
  output logic [ARCHBITSZ-1:0]   pi1_data_o,
  input  logic [ARCHBITSZ-1:0]   pi1_data_i,
  output logic [ARCHBITSZ/8-1:0] pi1_sel_o,
  input  logic                   pi1_rdy_i
);

  localparam int NB   = ARCHBITSZ / 8;
  localparam int IDXW = $clog2(NB);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_WRITE   = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  localparam logic [1:0] PINOOP = 2'd0;
  localparam logic [1:0] PIWROP = 2'd1;

  logic [1:0]           state_q, state_d;
  logic [IDXW-1:0]      idx_q, idx_d;
  logic [ADDRBITSZ-1:0] addr_q, addr_d;
  logic [ADDRBITSZ-1:0] rem_q, rem_d;
  logic [ARCHBITSZ-1:0] word_q, word_d;
  logic [ARCHBITSZ-1:0] sum_q, sum_d;

  // Read data port exists only to fit the master slot; it carries nothing here.
  logic unused_pi1_data;
  assign unused_pi1_data = ^pi1_data_i;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    word_d  = word_q;
    sum_d   = sum_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (wcnt_i != '0) begin
            addr_d  = base_addr_i;
            rem_d   = wcnt_i;
            sum_d   = '0;
            idx_d   = '0;
            state_d = ST_COLLECT;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_COLLECT: begin
        if (in_valid_i) begin
          word_d[{idx_q, 3'b000} +: 8] = in_data_i;
          if (idx_q == IDXW'(NB - 1)) begin
            idx_d   = '0;
            state_d = ST_WRITE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_WRITE: begin
        if (pi1_rdy_i) begin
          sum_d   = sum_q + word_q;
          addr_d  = addr_q + 1'b1;
          rem_d   = rem_q - 1'b1;
          state_d = (rem_q == ADDRBITSZ'(1)) ? ST_DONE : ST_COLLECT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      addr_q  <= '0;
      rem_q   <= '0;
      word_q  <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      word_q  <= word_d;
      sum_q   <= sum_d;
    end
  end

  // Bus fields are forced to zero outside WRITE so the slot looks idle.
  assign in_ready_o = (state_q == ST_COLLECT);
  assign busy_o     = (state_q != ST_IDLE);
  assign done_o     = (state_q == ST_DONE);
  assign sum_o      = sum_q;
  assign pi1_op_o   = (state_q == ST_WRITE) ? PIWROP : PINOOP;
  assign pi1_addr_o = (state_q == ST_WRITE) ? addr_q : '0;
  assign pi1_data_o = (state_q == ST_WRITE) ? word_q : '0;
  assign pi1_sel_o  = (state_q == ST_WRITE) ? '1 : '0;

endmodule

// File: tb/tb_pi1_streamldr.sv
// Randomised bench for pi1_streamldr: drives byte loads and compares observed
// PI1 writes against a word/address model built from the input stream.
module tb_pi1_streamldr;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [29:0] base_addr_i;
  logic [29:0] wcnt_i;
  logic [7:0]  in_data_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic        busy_o;
  logic        done_o;
  logic [31:0] sum_o;
  logic [1:0]  pi1_op_o;
  logic [29:0] pi1_addr_o;
  logic [31:0] pi1_data_o;
  logic [31:0] pi1_data_i;
  logic [3:0]  pi1_sel_o;
  logic        pi1_rdy_i;

  pi1_streamldr #(.ARCHBITSZ(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .base_addr_i(base_addr_i), .wcnt_i(wcnt_i),
    .in_data_i(in_data_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .busy_o(busy_o), .done_o(done_o), .sum_o(sum_o),
    .pi1_op_o(pi1_op_o), .pi1_addr_o(pi1_addr_o), .pi1_data_o(pi1_data_o),
    .pi1_data_i(pi1_data_i), .pi1_sel_o(pi1_sel_o), .pi1_rdy_i(pi1_rdy_i)
  );

  always #5 clk_i = ~clk_i;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0]  stream[$];
  logic [29:0] wa_q[$];
  logic [31:0] wd_q[$];
  logic [3:0]  ws_q[$];
  logic [29:0] exp_a[$];
  logic [31:0] exp_d[$];
  logic [31:0] exp_sum;
  int bytes_acc, done_cnt, done_cyc, first_acc_cyc, last_wr_cyc;
  int stall_viol, rdy_viol, busy_viol, stall_cycles;
  bit timeout;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic fill_stream(input int n, input bit counting);
    stream.delete();
    for (int i = 0; i < n; i++)
      stream.push_back(counting ? 8'(i + 1) : 8'($urandom));
  endtask

  // Reference: word i is bytes 4i..4i+3 little-endian, written at base+i mod 2^30.
  task automatic model_load(input logic [29:0] base, input logic [29:0] wcnt);
    logic [31:0] w;
    exp_a.delete();
    exp_d.delete();
    exp_sum = 32'h0;
    for (int i = 0; i < int'(wcnt); i++) begin
      w = {stream[4*i+3], stream[4*i+2], stream[4*i+1], stream[4*i]};
      exp_a.push_back(base + 30'(i));
      exp_d.push_back(w);
      exp_sum = exp_sum + w;
    end
  endtask

  // Drives one load (start in cycle 0) and records everything seen on the bus.
  // rmode: 0 rdy always 1, 1 hold rdy low 5 cycles per write, 2 random rdy.
  task automatic run_load(input logic [29:0] base, input logic [29:0] wcnt,
                          input int gap_pct, input int rmode, input int ss_cyc);
    int c = 0;
    int hold = 0;
    bit prev_stall = 0;
    logic [1:0]  p_op;
    logic [29:0] p_addr;
    logic [31:0] p_data;
    logic [3:0]  p_sel;
    wa_q.delete(); wd_q.delete(); ws_q.delete();
    bytes_acc = 0; done_cnt = 0; done_cyc = -1; first_acc_cyc = -1; last_wr_cyc = -1;
    stall_viol = 0; rdy_viol = 0; busy_viol = 0; stall_cycles = 0; timeout = 0;
    p_op = '0; p_addr = '0; p_data = '0; p_sel = '0;
    forever begin
      start_i     = (c == 0) || (c == ss_cyc);
      base_addr_i = (c == 0) ? base : 30'($urandom);
      wcnt_i      = (c == 0) ? wcnt : 30'($urandom_range(1, 9));
      in_valid_i  = (bytes_acc < stream.size()) && ($urandom_range(0, 99) >= gap_pct);
      in_data_i   = in_valid_i ? stream[bytes_acc] : 8'($urandom);
      if (pi1_op_o == 2'd1) begin
        if (rmode == 1 && hold < 5) begin
          pi1_rdy_i = 1'b0;
          hold++;
        end else if (rmode == 2) pi1_rdy_i = 1'($urandom_range(0, 1));
        else pi1_rdy_i = 1'b1;
      end else begin
        hold = 0;
        pi1_rdy_i = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      end
      @(negedge clk_i);
      if (done_o) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (c >= 1 && (done_cyc < 0 || c <= done_cyc) && !busy_o) busy_viol++;
      if (in_valid_i && in_ready_o) begin
        if (first_acc_cyc < 0) first_acc_cyc = c;
        bytes_acc++;
      end
      if (pi1_op_o == 2'd1 && in_ready_o) rdy_viol++;
      if (pi1_op_o != 2'd0 && pi1_op_o != 2'd1) stall_viol++;
      if (prev_stall && (pi1_op_o !== p_op || pi1_addr_o !== p_addr ||
                         pi1_data_o !== p_data || pi1_sel_o !== p_sel)) stall_viol++;
      if (pi1_op_o == 2'd1) begin
        if (pi1_rdy_i) begin
          wa_q.push_back(pi1_addr_o);
          wd_q.push_back(pi1_data_o);
          ws_q.push_back(pi1_sel_o);
          last_wr_cyc = c;
        end else stall_cycles++;
      end
      prev_stall = (pi1_op_o == 2'd1) && !pi1_rdy_i;
      p_op = pi1_op_o; p_addr = pi1_addr_o; p_data = pi1_data_o; p_sel = pi1_sel_o;
      c++;
      if (done_cyc >= 0 && c > done_cyc + 3) break;
      if (c > 3000) begin
        timeout = 1;
        break;
      end
      step();
    end
    step();
    start_i = 1'b0;
    in_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; start_i = 1'b0; base_addr_i = '0; wcnt_i = '0;
    in_data_i = '0; in_valid_i = 1'b0; pi1_data_i = 32'hDEADBEEF; pi1_rdy_i = 1'b1;
    repeat (3) step();
    @(negedge clk_i);
    tests_run++;
    if ({in_ready_o, busy_o, done_o} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_flags: got rdy/busy/done=%b expected 000", {in_ready_o, busy_o, done_o});
    end
    tests_run++;
    if (sum_o !== 32'h0 || pi1_op_o !== 2'd0) begin
      tests_failed++;
      $display("FAIL reset_sum_op: got sum=%h op=%0d expected 0/0", sum_o, pi1_op_o);
    end
    tests_run++;
    if (pi1_addr_o !== 30'h0 || pi1_data_o !== 32'h0 || pi1_sel_o !== 4'h0) begin
      tests_failed++;
      $display("FAIL reset_bus: got addr=%h data=%h sel=%h expected zeros", pi1_addr_o, pi1_data_o, pi1_sel_o);
    end
    $display("[TB] reset: rdy=%b busy=%b done=%b op=%0d", in_ready_o, busy_o, done_o, pi1_op_o);
    step();
    rst_i = 1'b0;
    step();
  endtask

  task automatic test_basic();
    fill_stream(8, 1'b1);
    model_load(30'h400, 30'd2);
    run_load(30'h400, 30'd2, 0, 0, -1);
    tests_run++;
    if (wa_q.size() != 2 || timeout) begin
      tests_failed++;
      $display("FAIL basic_count: got %0d writes (timeout=%0b) expected 2", wa_q.size(), timeout);
    end else begin
      tests_run++;
      if (wa_q[0] !== 30'h400 || wd_q[0] !== 32'h04030201 || ws_q[0] !== 4'hf) begin
        tests_failed++;
        $display("FAIL basic_w0: got %h/%h/%h expected 400/04030201/f", wa_q[0], wd_q[0], ws_q[0]);
      end
      tests_run++;
      if (wa_q[1] !== 30'h401 || wd_q[1] !== 32'h08070605 || ws_q[1] !== 4'hf) begin
        tests_failed++;
        $display("FAIL basic_w1: got %h/%h/%h expected 401/08070605/f", wa_q[1], wd_q[1], ws_q[1]);
      end
    end
    tests_run++;
    if (sum_o !== 32'h0C0A0806) begin
      tests_failed++;
      $display("FAIL basic_sum: got %h expected 0c0a0806", sum_o);
    end
    tests_run++;
    if (done_cnt != 1 || done_cyc != last_wr_cyc + 1) begin
      tests_failed++;
      $display("FAIL basic_done: got %0d pulses at cyc %0d expected 1 at cyc %0d", done_cnt, done_cyc, last_wr_cyc + 1);
    end
    tests_run++;
    if (first_acc_cyc != 1 || busy_viol != 0) begin
      tests_failed++;
      $display("FAIL basic_latency: got first accept cyc %0d busy_viol %0d expected 1/0", first_acc_cyc, busy_viol);
    end
    $display("[TB] basic: writes=%0d sum=%h done_cyc=%0d", wa_q.size(), sum_o, done_cyc);
  endtask

  task automatic test_stall();
    fill_stream(8, 1'b1);
    model_load(30'h400, 30'd2);
    run_load(30'h400, 30'd2, 0, 1, -1);
    tests_run++;
    if (wa_q.size() != 2 || wd_q[0] !== exp_d[0] || wd_q[1] !== exp_d[1] ||
        wa_q[0] !== exp_a[0] || wa_q[1] !== exp_a[1]) begin
      tests_failed++;
      $display("FAIL stall_writes: got %0d writes expected 2 matching model", wa_q.size());
    end
    tests_run++;
    if (stall_viol != 0 || rdy_viol != 0 || stall_cycles != 10) begin
      tests_failed++;
      $display("FAIL stall_hold: got unstable=%0d ready_in_write=%0d stalls=%0d expected 0/0/10", stall_viol, rdy_viol, stall_cycles);
    end
    tests_run++;
    if (sum_o !== exp_sum || done_cnt != 1) begin
      tests_failed++;
      $display("FAIL stall_sum: got sum=%h done=%0d expected %h/1", sum_o, done_cnt, exp_sum);
    end
    $display("[TB] stall: writes=%0d stalls=%0d sum=%h", wa_q.size(), stall_cycles, sum_o);
  endtask

  task automatic test_zero();
    fill_stream(4, 1'b0);
    run_load(30'h123, 30'd0, 0, 0, -1);
    tests_run++;
    if (wa_q.size() != 0 || bytes_acc != 0) begin
      tests_failed++;
      $display("FAIL zero_traffic: got writes=%0d bytes=%0d expected 0/0", wa_q.size(), bytes_acc);
    end
    tests_run++;
    if (done_cnt != 1 || done_cyc < 1 || done_cyc > 2 || timeout) begin
      tests_failed++;
      $display("FAIL zero_done: got %0d pulses at cyc %0d expected 1 at cyc 1..2", done_cnt, done_cyc);
    end
    $display("[TB] zero: done_cyc=%0d writes=%0d", done_cyc, wa_q.size());
  endtask

  task automatic test_wrap();
    fill_stream(8, 1'b0);
    model_load(30'h3FFFFFFF, 30'd2);
    run_load(30'h3FFFFFFF, 30'd2, 0, 0, -1);
    tests_run++;
    if (wa_q.size() != 2 || wa_q[0] !== 30'h3FFFFFFF || wa_q[1] !== 30'h0) begin
      tests_failed++;
      $display("FAIL wrap_addr: got %0d writes first=%h second=%h expected 3fffffff then 0",
               wa_q.size(), (wa_q.size() > 0) ? wa_q[0] : 30'h0, (wa_q.size() > 1) ? wa_q[1] : 30'h0);
    end
    tests_run++;
    if (wa_q.size() != 2 || wd_q[0] !== exp_d[0] || wd_q[1] !== exp_d[1] || sum_o !== exp_sum) begin
      tests_failed++;
      $display("FAIL wrap_data: got sum=%h expected %h", sum_o, exp_sum);
    end
    $display("[TB] wrap: writes=%0d sum=%h", wa_q.size(), sum_o);
  endtask

  task automatic test_gaps_restart();
    logic [29:0] ref_a[$];
    logic [31:0] ref_d[$];
    fill_stream(20, 1'b0);
    model_load(30'h0ABC, 30'd5);
    run_load(30'h0ABC, 30'd5, 0, 0, -1);
    ref_a = wa_q;
    ref_d = wd_q;
    run_load(30'h0ABC, 30'd5, 45, 2, 6);
    tests_run++;
    if (wa_q != ref_a || wd_q != ref_d) begin
      tests_failed++;
      $display("FAIL gaps_vs_gapfree: got %0d writes expected %0d identical", wa_q.size(), ref_a.size());
    end
    tests_run++;
    if (wa_q != exp_a || wd_q != exp_d || sum_o !== exp_sum || timeout) begin
      tests_failed++;
      $display("FAIL gaps_model: got sum=%h expected %h (timeout=%0b)", sum_o, exp_sum, timeout);
    end
    tests_run++;
    if (bytes_acc != 20 || done_cnt != 1 || rdy_viol != 0 || stall_viol != 0) begin
      tests_failed++;
      $display("FAIL gaps_protocol: got bytes=%0d done=%0d viol=%0d/%0d expected 20/1/0/0",
               bytes_acc, done_cnt, rdy_viol, stall_viol);
    end
    $display("[TB] gaps+restart: writes=%0d sum=%h", wa_q.size(), sum_o);
  endtask

  task automatic test_reset_mid_write();
    int bi = 0;
    bit seen = 0;
    fill_stream(4, 1'b0);
    start_i = 1'b1; base_addr_i = 30'h100; wcnt_i = 30'd3; pi1_rdy_i = 1'b0;
    step();
    start_i = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      in_valid_i = (bi < 4);
      in_data_i  = (bi < 4) ? stream[bi] : 8'h00;
      @(negedge clk_i);
      if (in_valid_i && in_ready_o) bi++;
      if (pi1_op_o == 2'd1) seen = 1;
      step();
    end
    in_valid_i = 1'b0;
    tests_run++;
    if (!seen) begin
      tests_failed++;
      $display("FAIL rstmid_reach: got no write op within 20 cycles expected one");
    end
    rst_i = 1'b1;
    step();
    @(negedge clk_i);
    tests_run++;
    if (pi1_op_o !== 2'd0 || {in_ready_o, busy_o, done_o} !== 3'b000 || sum_o !== 32'h0 ||
        pi1_addr_o !== 30'h0 || pi1_data_o !== 32'h0 || pi1_sel_o !== 4'h0) begin
      tests_failed++;
      $display("FAIL rstmid_outputs: got op=%0d flags=%b sum=%h addr=%h data=%h sel=%h expected all zero",
               pi1_op_o, {in_ready_o, busy_o, done_o}, sum_o, pi1_addr_o, pi1_data_o, pi1_sel_o);
    end
    step();
    rst_i = 1'b0;
    step();
    fill_stream(8, 1'b0);
    model_load(30'h2A0, 30'd2);
    run_load(30'h2A0, 30'd2, 20, 2, -1);
    tests_run++;
    if (wa_q != exp_a || wd_q != exp_d || sum_o !== exp_sum || done_cnt != 1) begin
      tests_failed++;
      $display("FAIL rstmid_reload: got %0d writes sum=%h expected %0d/%h", wa_q.size(), sum_o, exp_a.size(), exp_sum);
    end
    $display("[TB] reset mid-write then reload: writes=%0d sum=%h", wa_q.size(), sum_o);
  endtask

  task automatic test_random();
    logic [29:0] base;
    logic [29:0] wcnt;
    for (int it = 0; it < 5; it++) begin
      base = 30'($urandom);
      wcnt = 30'($urandom_range(1, 6));
      fill_stream(4 * int'(wcnt), 1'b0);
      model_load(base, wcnt);
      run_load(base, wcnt, $urandom_range(0, 60), $urandom_range(1, 2), $urandom_range(2, 10));
      tests_run++;
      if (wa_q != exp_a || wd_q != exp_d || sum_o !== exp_sum || done_cnt != 1 ||
          stall_viol != 0 || rdy_viol != 0 || busy_viol != 0 || timeout) begin
        tests_failed++;
        $display("FAIL random_%0d: got %0d writes sum=%h done=%0d expected %0d/%h/1",
                 it, wa_q.size(), sum_o, done_cnt, exp_a.size(), exp_sum);
      end
      $display("[TB] random %0d: base=%h wcnt=%0d sum=%h", it, base, wcnt, sum_o);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_zero();
    test_wrap();
    test_gaps_restart();
    test_reset_mid_write();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
